// File: rtl/axi_lite_master.sv
// rtl/axi_lite_master.sv - single-outstanding AXI4-Lite master behind a command/response handshake
// Optional response-wait timeout enabled by defining AXIL_MASTER_TIMEOUT_EN.
module axi_lite_master #(
    parameter int CSR_ADDR_WIDTH = 8,
    parameter int CSR_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [CSR_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [CSR_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [CSR_DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [CSR_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                    rsp_resp,
    output logic                          rsp_timeout,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [CSR_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                    m_axi_awprot,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    output logic [CSR_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [CSR_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready,
    input  logic [1:0]                    m_axi_bresp,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    output logic [CSR_ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]                    m_axi_arprot,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready,
    input  logic [CSR_DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    output logic                          busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t state, next_state;

    logic                      cmd_fire;
    logic                      aw_fire;
    logic                      w_fire;
    logic                      b_fire;
    logic                      ar_fire;
    logic                      r_fire;
    logic                      timeout_hit;
    logic [CSR_ADDR_WIDTH-1:0] addr_q;

    assign cmd_ready    = (state == IDLE);
    assign busy         = (state != IDLE);
    assign cmd_fire     = cmd_valid && cmd_ready;
    assign aw_fire      = m_axi_awvalid && m_axi_awready;
    assign w_fire       = m_axi_wvalid && m_axi_wready;
    assign b_fire       = m_axi_bvalid && m_axi_bready;
    assign ar_fire      = m_axi_arvalid && m_axi_arready;
    assign r_fire       = m_axi_rvalid && m_axi_rready;
    assign m_axi_awaddr = addr_q;
    assign m_axi_araddr = addr_q;
    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A channel whose valid is already low has completed its handshake earlier.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (cmd_fire) begin
                    next_state = cmd_write ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                if ((!m_axi_awvalid || aw_fire) && (!m_axi_wvalid || w_fire)) begin
                    next_state = WR_RESP;
                end
            end
            WR_RESP: begin
                if (b_fire || timeout_hit) begin
                    next_state = DONE;
                end
            end
            RD_REQ: begin
                if (ar_fire) begin
                    next_state = RD_RESP;
                end
            end
            RD_RESP: begin
                if (r_fire || timeout_hit) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q        <= '0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_rready  <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= 2'b00;
        end else begin
            if (cmd_fire) begin
                addr_q        <= cmd_addr;
                m_axi_wdata   <= cmd_wdata;
                m_axi_wstrb   <= cmd_wstrb;
                m_axi_awvalid <= cmd_write;
                m_axi_wvalid  <= cmd_write;
                m_axi_arvalid <= !cmd_write;
            end else begin
                if (aw_fire) m_axi_awvalid <= 1'b0;
                if (w_fire)  m_axi_wvalid  <= 1'b0;
                if (ar_fire) m_axi_arvalid <= 1'b0;
            end
            m_axi_bready <= (next_state == WR_RESP);
            m_axi_rready <= (next_state == RD_RESP);
            rsp_valid    <= (next_state == DONE);
            if (b_fire) begin
                rsp_rdata <= '0;
                rsp_resp  <= m_axi_bresp;
            end else if (r_fire) begin
                rsp_rdata <= m_axi_rdata;
                rsp_resp  <= m_axi_rresp;
            end else if (timeout_hit) begin
                rsp_rdata <= '0;
                rsp_resp  <= 2'b10;
            end
        end
    end

`ifdef AXIL_MASTER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] wait_cnt;
    logic            in_resp;

    assign in_resp     = (state == WR_RESP) || (state == RD_RESP);
    assign timeout_hit = in_resp && (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1)) && !b_fire && !r_fire;

    // Counter is zero on the first cycle of a response-wait state.
    always_ff @(posedge clk) begin
        if (!rst_n || !in_resp) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_timeout <= 1'b0;
        end else if (b_fire || r_fire) begin
            rsp_timeout <= 1'b0;
        end else if (timeout_hit) begin
            rsp_timeout <= 1'b1;
        end
    end
`else
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
    assign rsp_timeout = 1'b0;
`endif

endmodule
